// File: rtl/fetch_pkg.sv
// Shared constants and types for the fetch stage: NOP encoding, PC step and fetch FSM states.
package fetch_pkg;

  localparam logic [31:0] INSTR_NOP = 32'h0100_0000;
  localparam int unsigned PC_INC    = 4;

  typedef enum logic {
    StBoot,
    StRun
  } fetch_state_e;

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: holds on stall, loads fetched instruction or a NOP bubble,
// and clears to a bubble on synchronous reset.
module if_id_reg
  import fetch_pkg::*;
#(
  parameter int unsigned ADDR_W  = 32,
  parameter int unsigned INSTR_W = 32
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic               bubble,
  input  logic [INSTR_W-1:0] instr_F,
  input  logic [ADDR_W-1:0]  pc_F,
  input  logic [ADDR_W-1:0]  npc_F,
  output logic [INSTR_W-1:0] instr_D,
  output logic [ADDR_W-1:0]  pc_D,
  output logic [ADDR_W-1:0]  npc_D,
  output logic               valid_D
);

  logic [INSTR_W-1:0] instr_q, instr_d;
  logic [ADDR_W-1:0]  pc_q, pc_d;
  logic [ADDR_W-1:0]  npc_q, npc_d;
  logic               valid_q, valid_d;

  always_comb begin
    instr_d = instr_q;
    pc_d    = pc_q;
    npc_d   = npc_q;
    valid_d = valid_q;
    if (load) begin
      // An annulled delay slot still carries its real PC/nPC for debug and trace.
      instr_d = bubble ? INSTR_W'(INSTR_NOP) : instr_F;
      valid_d = ~bubble;
      pc_d    = pc_F;
      npc_d   = npc_F;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      instr_q <= INSTR_W'(INSTR_NOP);
      pc_q    <= '0;
      npc_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      instr_q <= instr_d;
      pc_q    <= pc_d;
      npc_q   <= npc_d;
      valid_q <= valid_d;
    end
  end

  assign instr_D = instr_q;
  assign pc_D    = pc_q;
  assign npc_D   = npc_q;
  assign valid_D = valid_q;

endmodule

// File: rtl/fetch_unit.sv
// PC/nPC fetch stage with delayed-branch sequencing, pending redirects and annulled delay slots.
// Optional FETCH_PERF_EN adds saturating fetch and stall counters.
module fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned       ADDR_W   = 32,
  parameter int unsigned       INSTR_W  = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               stall_F,
  input  logic               stall_D,
  input  logic               redirect_valid,
  input  logic [ADDR_W-1:0]  redirect_target,
  input  logic               redirect_annul,
  output logic [ADDR_W-1:0]  imem_addr,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic [INSTR_W-1:0] instr_D,
  output logic [ADDR_W-1:0]  pc_D,
  output logic [ADDR_W-1:0]  npc_D,
`ifdef FETCH_PERF_EN
  output logic [31:0]        perf_fetched,
  output logic [31:0]        perf_stalls,
`endif
  output logic               valid_D
);

  fetch_state_e      state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] npc_q, npc_d;
  logic              pend_valid_q, pend_valid_d;
  logic [ADDR_W-1:0] pend_target_q, pend_target_d;
  logic              pend_annul_q, pend_annul_d;
  logic              annul_q, annul_d;

  logic              apply_redirect;
  logic [ADDR_W-1:0] redirect_tgt;
  logic              redirect_ann;

  always_comb begin
    // A live redirect outranks a pending one in the cycle the stall lifts.
    apply_redirect = ~stall_F & (redirect_valid | pend_valid_q);
    redirect_tgt   = redirect_valid ? redirect_target : pend_target_q;
    redirect_ann   = redirect_valid ? redirect_annul : pend_annul_q;

    pc_d          = pc_q;
    npc_d         = npc_q;
    pend_valid_d  = pend_valid_q;
    pend_target_d = pend_target_q;
    pend_annul_d  = pend_annul_q;
    annul_d       = annul_q;
    state_d       = state_q;

    if (!stall_F) begin
      pc_d         = npc_q;
      npc_d        = apply_redirect ? redirect_tgt : npc_q + ADDR_W'(PC_INC);
      pend_valid_d = 1'b0;
    end else if (redirect_valid) begin
      pend_valid_d  = 1'b1;
      pend_target_d = redirect_target;
      pend_annul_d  = redirect_annul;
    end

    // The flag targets the delay slot, i.e. the load after the one happening now.
    if (apply_redirect && redirect_ann) begin
      annul_d = 1'b1;
    end else if (!stall_D) begin
      annul_d = 1'b0;
    end

    unique case (state_q)
      StBoot:  if (!stall_D) state_d = StRun;
      StRun:   state_d = StRun;
      default: state_d = StBoot;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= StBoot;
      pc_q          <= RESET_PC;
      npc_q         <= RESET_PC + ADDR_W'(PC_INC);
      pend_valid_q  <= 1'b0;
      pend_target_q <= '0;
      pend_annul_q  <= 1'b0;
      annul_q       <= 1'b0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      npc_q         <= npc_d;
      pend_valid_q  <= pend_valid_d;
      pend_target_q <= pend_target_d;
      pend_annul_q  <= pend_annul_d;
      annul_q       <= annul_d;
    end
  end

  assign imem_addr = pc_q;

  if_id_reg #(
    .ADDR_W  (ADDR_W),
    .INSTR_W (INSTR_W)
  ) u_if_id_reg (
    .clk     (clk),
    .reset   (reset),
    .load    (~stall_D),
    .bubble  (annul_q),
    .instr_F (imem_rdata),
    .pc_F    (pc_q),
    .npc_F   (npc_q),
    .instr_D (instr_D),
    .pc_D    (pc_D),
    .npc_D   (npc_D),
    .valid_D (valid_D)
  );

`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched_q, perf_stalls_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_fetched_q <= '0;
      perf_stalls_q  <= '0;
    end else begin
      if (!stall_D && !annul_q && perf_fetched_q != '1) perf_fetched_q <= perf_fetched_q + 32'd1;
      if (stall_F && perf_stalls_q != '1) perf_stalls_q <= perf_stalls_q + 32'd1;
    end
  end

  assign perf_fetched = perf_fetched_q;
  assign perf_stalls  = perf_stalls_q;
`endif

`ifndef SYNTHESIS
  // Hazard unit must never freeze PC while letting IF/ID advance.
  stall_order_a: assert property (@(posedge clk) disable iff (reset) !(stall_F && !stall_D));
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios plus randomized traffic vs a reference model.
module tb_fetch_unit;
  import fetch_pkg::*;

  localparam logic [31:0] TAG = 32'h5A00_0000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1, stall_F = 1'b0, stall_D = 1'b0;
  logic        redirect_valid = 1'b0, redirect_annul = 1'b0;
  logic [31:0] redirect_target = '0;

  logic [31:0] imem_addr, imem_rdata, instr_D, pc_D, npc_D;
  logic        valid_D;
  logic [31:0] imem_addr_b, imem_rdata_b, instr_D_b, pc_D_b, npc_D_b;
  logic        valid_D_b;
`ifdef FETCH_PERF_EN
  logic [31:0] perf_fetched, perf_stalls, perf_fetched_b, perf_stalls_b;
`endif

  assign imem_rdata   = imem_addr ^ TAG;
  assign imem_rdata_b = imem_addr_b ^ TAG;

  fetch_unit dut (
    .clk(clk), .reset(reset), .stall_F(stall_F), .stall_D(stall_D),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .redirect_annul(redirect_annul), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .instr_D(instr_D), .pc_D(pc_D), .npc_D(npc_D),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched), .perf_stalls(perf_stalls),
`endif
    .valid_D(valid_D)
  );

  fetch_unit #(.RESET_PC(32'h40)) dut40 (
    .clk(clk), .reset(reset), .stall_F(stall_F), .stall_D(stall_D),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .redirect_annul(redirect_annul), .imem_addr(imem_addr_b), .imem_rdata(imem_rdata_b),
    .instr_D(instr_D_b), .pc_D(pc_D_b), .npc_D(npc_D_b),
`ifdef FETCH_PERF_EN
    .perf_fetched(perf_fetched_b), .perf_stalls(perf_stalls_b),
`endif
    .valid_D(valid_D_b)
  );

  int n_cmp = 0;
  int n_bad = 0;

  // Reference model of the RESET_PC=0 instance.
  logic [31:0] m_pc, m_npc, m_pend_t, m_instr, m_pcd, m_npcd;
  logic        m_pend_v, m_pend_a, m_annul, m_valid;

  function automatic logic [31:0] tag(input logic [31:0] a);
    return a ^ TAG;
  endfunction

  function void model_step();
    logic        apply, tann;
    logic [31:0] tgt;
    if (reset) begin
      m_pc = 32'h0; m_npc = 32'h4; m_pend_v = 0; m_pend_t = '0; m_pend_a = 0; m_annul = 0;
      m_instr = INSTR_NOP; m_pcd = '0; m_npcd = '0; m_valid = 0;
      return;
    end
    apply = !stall_F && (redirect_valid || m_pend_v);
    tgt   = redirect_valid ? redirect_target : m_pend_t;
    tann  = redirect_valid ? redirect_annul : m_pend_a;
    if (!stall_D) begin
      m_pcd = m_pc; m_npcd = m_npc;
      m_instr = m_annul ? INSTR_NOP : tag(m_pc);
      m_valid = !m_annul;
      m_annul = 0;
    end
    if (apply && tann) m_annul = 1;
    if (!stall_F) begin
      m_pc = m_npc;
      m_npc = apply ? tgt : m_npc + 32'd4;
      m_pend_v = 0;
    end else if (redirect_valid) begin
      m_pend_v = 1; m_pend_t = redirect_target; m_pend_a = redirect_annul;
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
  endtask

  task automatic do_reset();
    reset = 1; stall_F = 0; stall_D = 0; redirect_valid = 0; redirect_annul = 0;
    redirect_target = '0;
    tick(); tick();
    reset = 0;
  endtask

  task automatic test_reset();
    do_reset();
    n_cmp++; if (imem_addr !== 32'h0) begin n_bad++; $display("FAIL reset_pc: got %h want %h", imem_addr, 32'h0); end
    n_cmp++; if (instr_D !== INSTR_NOP) begin n_bad++; $display("FAIL reset_instr: got %h want %h", instr_D, INSTR_NOP); end
    n_cmp++; if (pc_D !== 32'h0 || npc_D !== 32'h0) begin n_bad++; $display("FAIL reset_pcd: got %h/%h want 0/0", pc_D, npc_D); end
    n_cmp++; if (valid_D !== 1'b0) begin n_bad++; $display("FAIL reset_valid: got %b want 0", valid_D); end
    n_cmp++; if (imem_addr_b !== 32'h40) begin n_bad++; $display("FAIL reset_pc40: got %h want %h", imem_addr_b, 32'h40); end
  endtask

  task automatic test_sequential();
    for (int i = 0; i < 6; i++) begin
      n_cmp++; if (imem_addr !== 32'(4 * i)) begin n_bad++; $display("FAIL seq_addr: got %h want %h", imem_addr, 32'(4 * i)); end
      tick();
      n_cmp++;
      if (pc_D !== 32'(4 * i) || instr_D !== tag(32'(4 * i)) || valid_D !== 1'b1) begin
        n_bad++;
        $display("FAIL seq_ifid: got pc %h instr %h v %b want pc %h instr %h v 1",
                 pc_D, instr_D, valid_D, 32'(4 * i), tag(32'(4 * i)));
      end
    end
  endtask

  task automatic test_stall();
    do_reset(); tick(); tick();
    stall_F = 1; stall_D = 1;
    repeat (2) begin
      tick();
      n_cmp++; if (imem_addr !== 32'h8) begin n_bad++; $display("FAIL stall_addr: got %h want %h", imem_addr, 32'h8); end
      n_cmp++; if (pc_D !== 32'h4 || instr_D !== tag(32'h4)) begin n_bad++; $display("FAIL stall_ifid: got %h/%h want %h/%h", pc_D, instr_D, 32'h4, tag(32'h4)); end
    end
    stall_F = 0; stall_D = 0;
    tick();
    n_cmp++; if (imem_addr !== 32'hC || pc_D !== 32'h8) begin n_bad++; $display("FAIL stall_resume: got %h/%h want c/8", imem_addr, pc_D); end
  endtask

  task automatic test_redirect(input logic annul);
    do_reset(); repeat (4) tick();
    n_cmp++; if (imem_addr !== 32'h10) begin n_bad++; $display("FAIL br_start: got %h want %h", imem_addr, 32'h10); end
    redirect_valid = 1; redirect_target = 32'h100; redirect_annul = annul;
    tick();
    redirect_valid = 0; redirect_annul = 0;
    n_cmp++; if (imem_addr !== 32'h14 || pc_D !== 32'h10) begin n_bad++; $display("FAIL br_slot_fetch: got %h/%h want 14/10", imem_addr, pc_D); end
    tick();
    n_cmp++; if (imem_addr !== 32'h100) begin n_bad++; $display("FAIL br_target: got %h want %h", imem_addr, 32'h100); end
    n_cmp++;
    if (pc_D !== 32'h14 || npc_D !== 32'h100 || valid_D !== !annul ||
        instr_D !== (annul ? INSTR_NOP : tag(32'h14))) begin
      n_bad++;
      $display("FAIL br_slot_ifid: got %h/%h/%h/%b annul %b", pc_D, npc_D, instr_D, valid_D, annul);
    end
    tick();
    n_cmp++; if (imem_addr !== 32'h104 || pc_D !== 32'h100 || valid_D !== 1'b1) begin n_bad++; $display("FAIL br_after: got %h/%h/%b want 104/100/1", imem_addr, pc_D, valid_D); end
  endtask

  task automatic test_pending_redirect();
    do_reset(); repeat (4) tick();
    stall_F = 1; stall_D = 1;
    redirect_valid = 1; redirect_target = 32'h200;
    tick();
    redirect_valid = 0;
    repeat (3) begin
      n_cmp++; if (imem_addr !== 32'h10 || pc_D !== 32'hC) begin n_bad++; $display("FAIL pend_hold: got %h/%h want 10/c", imem_addr, pc_D); end
      tick();
    end
    stall_F = 0; stall_D = 0;
    tick();
    n_cmp++; if (imem_addr !== 32'h14) begin n_bad++; $display("FAIL pend_slot: got %h want %h", imem_addr, 32'h14); end
    tick();
    n_cmp++; if (imem_addr !== 32'h200) begin n_bad++; $display("FAIL pend_target: got %h want %h", imem_addr, 32'h200); end
  endtask

  task automatic test_reset_mid_pending();
    do_reset(); tick(); tick();
    stall_F = 1; stall_D = 1;
    redirect_valid = 1; redirect_target = 32'h300;
    tick();
    redirect_valid = 0; reset = 1;
    tick();
    reset = 0; stall_F = 0; stall_D = 0;
    n_cmp++; if (imem_addr_b !== 32'h40 || valid_D_b !== 1'b0) begin n_bad++; $display("FAIL rst_pend_pc: got %h/%b want 40/0", imem_addr_b, valid_D_b); end
`ifdef FETCH_PERF_EN
    n_cmp++; if (perf_fetched !== 32'h0 || perf_stalls !== 32'h0) begin n_bad++; $display("FAIL rst_perf: got %h/%h want 0/0", perf_fetched, perf_stalls); end
`endif
    tick();
    n_cmp++; if (imem_addr_b !== 32'h44) begin n_bad++; $display("FAIL rst_pend_npc: got %h want %h", imem_addr_b, 32'h44); end
    tick();
    n_cmp++; if (imem_addr_b !== 32'h48 || pc_D_b !== 32'h44) begin n_bad++; $display("FAIL rst_pend_drop: got %h/%h want 48/44", imem_addr_b, pc_D_b); end
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      reset          = ($urandom_range(0, 99) == 0);
      stall_D        = ($urandom_range(0, 3) == 0);
      stall_F        = stall_D & $urandom_range(0, 1);
      redirect_valid = ($urandom_range(0, 6) == 0);
      redirect_annul = $urandom_range(0, 1);
      redirect_target = 32'($urandom_range(0, 32'h3FFF)) << 2;
      tick();
      n_cmp++; if (imem_addr !== m_pc) begin n_bad++; $display("FAIL rnd_addr: got %h want %h", imem_addr, m_pc); end
      n_cmp++; if (instr_D !== m_instr) begin n_bad++; $display("FAIL rnd_instr: got %h want %h", instr_D, m_instr); end
      n_cmp++; if (pc_D !== m_pcd || npc_D !== m_npcd) begin n_bad++; $display("FAIL rnd_pcd: got %h/%h want %h/%h", pc_D, npc_D, m_pcd, m_npcd); end
      n_cmp++; if (valid_D !== m_valid) begin n_bad++; $display("FAIL rnd_valid: got %b want %b", valid_D, m_valid); end
    end
    reset = 0; stall_F = 0; stall_D = 0; redirect_valid = 0;
  endtask

  initial begin
    test_reset();
    test_sequential();
    test_stall();
    test_redirect(1'b0);
    test_redirect(1'b1);
    test_pending_redirect();
    test_reset_mid_pending();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
